// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide, one bit per clock.
// Optional macro MULDIV_FAST_SPECIAL_EN: zero-operand, divide-by-zero and signed-overflow ops finish without iterating.
module muldiv_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned ITERS = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int unsigned AW = 2 * XLEN;
    localparam int unsigned CW = $clog2(ITERS);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [2:0]      f3;
    logic            neg;
    logic            dz;
    logic [XLEN-1:0] opnd;
    logic [AW-1:0]   acc;

    // Launch-time decode: operand magnitudes and result sign
    logic            sign_a, sign_b, a_neg, b_neg, neg_in;
    logic [XLEN-1:0] mag_a, mag_b;

    always_comb begin
        sign_a = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
        sign_b = sign_a && (funct3 != 3'b010);
        a_neg  = sign_a && op_a[XLEN-1];
        b_neg  = sign_b && op_b[XLEN-1];
        mag_a  = a_neg ? (~op_a + XLEN'(1)) : op_a;
        mag_b  = b_neg ? (~op_b + XLEN'(1)) : op_b;
        // Remainder takes the dividend's sign; everything else the XOR of operand signs
        neg_in = (funct3[2] && funct3[1]) ? a_neg : (a_neg ^ b_neg);
    end

    // One iteration step plus the final sign-corrected result
    logic [XLEN:0]   mul_sum, div_sh;
    logic [XLEN-1:0] div_diff;
    logic            div_ge;
    logic [AW-1:0]   acc_n, prod;
    logic [XLEN-1:0] quo, rem, fin;

    always_comb begin
        mul_sum  = {1'b0, acc[AW-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        div_sh   = {acc[AW-1:XLEN], acc[XLEN-1]};
        div_diff = XLEN'(div_sh - {1'b0, opnd});
        div_ge   = (div_sh >= {1'b0, opnd});
        if (f3[2]) begin
            acc_n = {(div_ge ? div_diff : div_sh[XLEN-1:0]), acc[XLEN-2:0], div_ge};
        end else begin
            acc_n = {mul_sum, acc[XLEN-1:1]};
        end
        prod = neg ? (~acc_n + AW'(1)) : acc_n;
        quo  = acc_n[XLEN-1:0];
        rem  = acc_n[AW-1:XLEN];
        if (!f3[2]) begin
            fin = (f3[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[AW-1:XLEN];
        end else if (f3[1]) begin
            fin = neg ? (~rem + XLEN'(1)) : rem;
        end else if (dz) begin
            fin = '1;
        end else begin
            fin = neg ? (~quo + XLEN'(1)) : quo;
        end
    end

`ifdef MULDIV_FAST_SPECIAL_EN
    logic            ovf, special;
    logic [XLEN-1:0] fast_res;

    always_comb begin
        ovf      = funct3[2] && !funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
        special  = (op_a == '0) || (op_b == '0) || ovf;
        fast_res = '0;
        if (funct3[2] && (op_b == '0)) begin
            fast_res = funct3[1] ? op_a : '1;
        end else if (ovf && !funct3[1]) begin
            fast_res = op_a;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            count  <= '0;
            f3     <= '0;
            neg    <= 1'b0;
            dz     <= 1'b0;
            opnd   <= '0;
            acc    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                CALC: begin
                    acc   <= acc_n;
                    count <= count + CW'(1);
                    if (count == CW'(ITERS - 1)) begin
                        state  <= DONE;
                        done   <= 1'b1;
                        result <= fin;
                        count  <= '0;
                    end
                end
                // IDLE and DONE both accept a new request
                default: begin
                    if (start) begin
                        f3    <= funct3;
                        neg   <= neg_in;
                        dz    <= (op_b == '0);
                        count <= '0;
                        busy  <= 1'b1;
                        opnd  <= funct3[2] ? mag_b : mag_a;
                        acc   <= {{XLEN{1'b0}}, (funct3[2] ? mag_a : mag_b)};
                        state <= CALC;
`ifdef MULDIV_FAST_SPECIAL_EN
                        if (special) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            result <= fast_res;
                        end
`endif
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: products, quotients, special cases, reset and back-to-back.
module tb_muldiv_unit;
    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

    // Special-case ops enter DONE on the launching edge when the fast path is built in
`ifdef MULDIV_FAST_SPECIAL_EN
    localparam int SP_LAT = 0;
`else
    localparam int SP_LAT = 32;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;

    muldiv_unit #(.XLEN(32), .ITERS(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    // Launch one op from IDLE; report result, edges from launch to done, and handshake health
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output bit busy_ok, output bit end_ok);
        @(negedge clk);
        funct3 = f; op_a = a; op_b = b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom;
        busy_ok = 1'b1;
        lat = 0;
        @(negedge clk);
        if (busy !== 1'b1) busy_ok = 1'b0;
        while (done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        res = result;
        @(posedge clk);
        @(negedge clk);
        end_ok = (done === 1'b0) && (busy === 1'b0);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: got busy=%b done=%b result=%h expected 0 0 00000000", busy, done, result);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_mul();
        logic [2:0]  f [7];
        logic [31:0] a [7];
        logic [31:0] b [7];
        logic [31:0] e [7];
        logic [31:0] res;
        int          lat;
        bit          bok, eok;
        f = '{F_MUL, F_MULHU, F_MULH, F_MULHSU, F_MULHU, F_MUL, F_MULH};
        a = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h00010000, 32'h80000000};
        b = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd4, 32'h00010000, 32'h80000000};
        e = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFF, 32'd2, 32'd0, 32'h40000000};
        for (int i = 0; i < 7; i++) begin
            run_op(f[i], a[i], b[i], res, lat, bok, eok);
            checks += 3;
            if (res !== e[i]) begin
                errors++;
                $display("FAIL mul[%0d] result: got %h expected %h", i, res, e[i]);
            end
            if (lat !== 32) begin
                errors++;
                $display("FAIL mul[%0d] latency: got %0d expected 32", i, lat);
            end
            if (!(bok && eok)) begin
                errors++;
                $display("FAIL mul[%0d] handshake: got busy_ok=%b end_ok=%b expected 1 1", i, bok, eok);
            end
        end
    endtask

    task automatic test_div();
        logic [2:0]  f [8];
        logic [31:0] a [8];
        logic [31:0] b [8];
        logic [31:0] e [8];
        int          el [8];
        logic [31:0] res;
        int          lat;
        bit          bok, eok;
        f  = '{F_DIV, F_REM, F_DIV, F_REM, F_DIVU, F_REMU, F_DIV, F_REM};
        a  = '{32'h80000000, 32'h80000000, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd7, 32'd7};
        b  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFE};
        e  = '{32'h80000000, 32'h00000000, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFD, 32'd1};
        el = '{SP_LAT, SP_LAT, 32, 32, 32, 32, 32, 32};
        for (int i = 0; i < 8; i++) begin
            run_op(f[i], a[i], b[i], res, lat, bok, eok);
            checks += 3;
            if (res !== e[i]) begin
                errors++;
                $display("FAIL div[%0d] result: got %h expected %h", i, res, e[i]);
            end
            if (lat !== el[i]) begin
                errors++;
                $display("FAIL div[%0d] latency: got %0d expected %0d", i, lat, el[i]);
            end
            if (!(bok && eok)) begin
                errors++;
                $display("FAIL div[%0d] handshake: got busy_ok=%b end_ok=%b expected 1 1", i, bok, eok);
            end
        end
    endtask

    task automatic test_special();
        logic [2:0]  f [7];
        logic [31:0] a [7];
        logic [31:0] b [7];
        logic [31:0] e [7];
        logic [31:0] res;
        int          lat;
        bit          bok, eok;
        f = '{F_DIVU, F_REMU, F_DIV, F_REM, F_MUL, F_MULHU, F_DIVU};
        a = '{32'd5, 32'd5, 32'hFFFFFFFB, 32'hFFFFFFFB, 32'd0, 32'h12345678, 32'd0};
        b = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd5, 32'd0, 32'd7};
        e = '{32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFB, 32'd0, 32'd0, 32'd0};
        for (int i = 0; i < 7; i++) begin
            run_op(f[i], a[i], b[i], res, lat, bok, eok);
            checks += 3;
            if (res !== e[i]) begin
                errors++;
                $display("FAIL special[%0d] result: got %h expected %h", i, res, e[i]);
            end
            if (lat !== SP_LAT) begin
                errors++;
                $display("FAIL special[%0d] latency: got %0d expected %0d", i, lat, SP_LAT);
            end
            if (!(bok && eok)) begin
                errors++;
                $display("FAIL special[%0d] handshake: got busy_ok=%b end_ok=%b expected 1 1", i, bok, eok);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        int          lat;
        bit          bok, eok;
        @(negedge clk);
        funct3 = F_DIVU; op_a = 32'd100; op_b = 32'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid: got busy=%b done=%b result=%h expected 0 0 00000000", busy, done, result);
        end
        @(negedge clk);
        reset = 1'b0;
        run_op(F_MUL, 32'd3, 32'd4, res, lat, bok, eok);
        checks += 3;
        if (res !== 32'd12) begin
            errors++;
            $display("FAIL post_reset_mul result: got %h expected 0000000c", res);
        end
        if (lat !== 32) begin
            errors++;
            $display("FAIL post_reset_mul latency: got %0d expected 32", lat);
        end
        if (!(bok && eok)) begin
            errors++;
            $display("FAIL post_reset_mul handshake: got busy_ok=%b end_ok=%b expected 1 1", bok, eok);
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        @(negedge clk);
        funct3 = F_MUL; op_a = 32'd3; op_b = 32'd5; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; funct3 = F_DIVU; op_a = 32'd100; op_b = 32'd7;
        for (int i = 1; i <= 66; i++) begin
            @(posedge clk);
            #1;
            // Stray pulse mid-CALC, then start held through DONE to chain the divide
            start = (i == 5) || (i >= 20 && i < 33);
            if (i == 33) op_a = 32'd9;
            @(negedge clk);
            if (done === 1'b1) pulses++;
            if (i == 32) begin
                checks++;
                if (done !== 1'b1 || result !== 32'd15) begin
                    errors++;
                    $display("FAIL b2b_first: got done=%b result=%h expected 1 0000000f", done, result);
                end
            end
            if (i == 33) begin
                checks++;
                if (done !== 1'b0 || busy !== 1'b1 || result !== 32'd15) begin
                    errors++;
                    $display("FAIL b2b_relaunch: got done=%b busy=%b result=%h expected 0 1 0000000f", done, busy, result);
                end
            end
            if (i == 64) begin
                checks++;
                if (pulses !== 1) begin
                    errors++;
                    $display("FAIL b2b_pulses: got %0d expected 1", pulses);
                end
            end
            if (i == 65) begin
                checks++;
                if (done !== 1'b1 || result !== 32'd14) begin
                    errors++;
                    $display("FAIL b2b_second: got done=%b result=%h expected 1 0000000e", done, result);
                end
            end
            if (i == 66) begin
                checks++;
                if (done !== 1'b0 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_idle: got done=%b busy=%b expected 0 0", done, busy);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_reset_mid();
        test_special();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
